// File: rtl/systarr_sched.sv
// Band scheduler for the DTW systolic array: preloads T bands, streams R, drives PE controls.
// Optional cycle statistics counter enabled by defining SYSTARR_SCHED_STAT_EN.
module systarr_sched #(
  parameter int N_PE  = 6,
  parameter int IDX_W = 5
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [IDX_W-1:0]    t_len,
  input  logic [IDX_W-1:0]    r_len,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                t_rd,
  output logic [IDX_W-1:0]    t_addr,
  output logic                r_rd,
  output logic [IDX_W-1:0]    r_addr,
  output logic                sa_ena,
  output logic [IDX_W-1:0]    sa_tindex,
  output logic [IDX_W-1:0]    sa_rindex,
  output logic [2*N_PE-1:0]   sa_tsrc,
  output logic [2*N_PE-1:0]   sa_rsrc,
  output logic [N_PE-1:0]     path_vld,
  output logic [IDX_W-1:0]    band_base
`ifdef SYSTARR_SCHED_STAT_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         stat_cycles
`endif
);

  localparam int CW = $clog2((1 << IDX_W) + N_PE + 1);
  localparam int AW = CW + 1;
  localparam logic [1:0] SRC_NB   = 2'b01;
  localparam logic [1:0] SRC_EXT  = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;
  localparam logic [IDX_W:0] IDX_MAX = {1'b0, {IDX_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_NEXT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt, cm1;
  logic [IDX_W-1:0]  tl_q, tl_nxt, rl_q, rl_nxt, bb_q, bb_nxt, bb_adv;
  logic [IDX_W:0]    bb_sum;
  logic              zdone_q, zdone_nxt, more;
  logic [AW-1:0]     row, trow;

  always_comb begin
    bb_sum = {1'b0, bb_q} + (IDX_W+1)'(N_PE);
    bb_adv = (bb_sum > IDX_MAX) ? IDX_MAX[IDX_W-1:0] : bb_sum[IDX_W-1:0];
    more   = bb_adv < tl_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tl_q    <= '0;
      rl_q    <= '0;
      bb_q    <= '0;
      zdone_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tl_q    <= tl_nxt;
      rl_q    <= rl_nxt;
      bb_q    <= bb_nxt;
      zdone_q <= zdone_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tl_nxt    = tl_q;
    rl_nxt    = rl_q;
    bb_nxt    = bb_q;
    zdone_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (t_len == '0 || r_len == '0) begin
            zdone_nxt = 1'b1;
          end else begin
            tl_nxt    = t_len;
            rl_nxt    = r_len;
            bb_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (!hold) begin
          if (cnt == CW'(N_PE)) begin
            cnt_nxt   = '0;
            state_nxt = S_STREAM;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      S_STREAM: begin
        if (!hold) begin
          if (cnt == CW'(rl_q) + CW'(N_PE - 1)) begin
            // Band advance folds into the last stream cycle; NEXT only closes the job.
            cnt_nxt   = '0;
            bb_nxt    = bb_adv;
            state_nxt = more ? S_LOAD : S_NEXT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      S_NEXT: begin
        if (!hold) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = zdone_q | ((state == S_NEXT) && !hold);
    band_base = bb_q;
    t_rd      = 1'b0;
    t_addr    = '0;
    r_rd      = 1'b0;
    r_addr    = '0;
    sa_ena    = 1'b0;
    sa_tindex = '0;
    sa_rindex = '0;
    sa_tsrc   = '0;
    sa_rsrc   = '0;
    path_vld  = '0;
    row       = AW'(bb_q) + AW'(cnt);
    trow      = row - AW'(1);
    cm1       = cnt - CW'(1);
    case (state)
      S_LOAD: begin
        if (cnt < CW'(N_PE)) begin
          t_addr = row[IDX_W-1:0];
          t_rd   = !hold && (row < AW'(tl_q));
        end
        if (cnt != '0) begin
          sa_ena    = !hold;
          sa_tindex = trow[IDX_W-1:0];
          for (int unsigned j = 0; j < N_PE - 1; j++)
            sa_tsrc[2*(N_PE-1-j) +: 2] = SRC_NB;
          // Rows past t_len enter the chain as zero.
          sa_tsrc[1:0] = (trow < AW'(tl_q)) ? SRC_EXT : SRC_ZERO;
        end
      end
      S_STREAM: begin
        if (cnt < CW'(rl_q)) begin
          r_rd   = !hold;
          r_addr = cnt[IDX_W-1:0];
        end
        if (cnt != '0) begin
          sa_ena    = !hold;
          sa_rindex = cm1[IDX_W-1:0];
          for (int unsigned j = 1; j < N_PE; j++)
            sa_rsrc[2*(N_PE-1-j) +: 2] = SRC_NB;
          sa_rsrc[2*N_PE-1 -: 2] = (cnt <= CW'(rl_q)) ? SRC_EXT : SRC_ZERO;
        end
        for (int unsigned j = 0; j < N_PE; j++) begin
          if (cnt >= CW'(j + 1) && cnt <= CW'(rl_q) + CW'(j) &&
              (AW'(bb_q) + AW'(j) < AW'(tl_q)))
            path_vld[N_PE-1-j] = !hold;
        end
      end
      default: ;
    endcase
  end

`ifdef SYSTARR_SCHED_STAT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stat_cycles <= '0;
    else if (stat_clr)
      stat_cycles <= '0;
    else if (busy && !hold && stat_cycles != '1)
      stat_cycles <= stat_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systarr_sched.sv
// Directed-vector bench for systarr_sched: job timing, addresses, source selects, masks, hold, reset.
module tb_systarr_sched;
  localparam int N_PE  = 6;
  localparam int IDX_W = 5;

  logic clk, nrst, start, hold;
  logic [IDX_W-1:0] t_len, r_len;
  logic busy, done, t_rd, r_rd, sa_ena;
  logic [IDX_W-1:0] t_addr, r_addr, sa_tindex, sa_rindex, band_base;
  logic [2*N_PE-1:0] sa_tsrc, sa_rsrc;
  logic [N_PE-1:0] path_vld;
`ifdef SYSTARR_SCHED_STAT_EN
  logic stat_clr;
  logic [15:0] stat_cycles;
`endif

  systarr_sched #(.N_PE(N_PE), .IDX_W(IDX_W)) dut (
    .clk(clk), .nrst(nrst), .start(start), .t_len(t_len), .r_len(r_len), .hold(hold),
    .busy(busy), .done(done), .t_rd(t_rd), .t_addr(t_addr), .r_rd(r_rd), .r_addr(r_addr),
    .sa_ena(sa_ena), .sa_tindex(sa_tindex), .sa_rindex(sa_rindex), .sa_tsrc(sa_tsrc),
    .sa_rsrc(sa_rsrc), .path_vld(path_vld), .band_base(band_base)
`ifdef SYSTARR_SCHED_STAT_EN
    , .stat_clr(stat_clr), .stat_cycles(stat_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int errors  = 0;
  int done_cyc, pv_bits, t_rds, r_rds, hold_viol;
  int done_seen;
  logic [N_PE-1:0]   pv_h    [64];
  logic              t_rd_h  [64];
  logic              r_rd_h  [64];
  logic              busy_h  [64];
  logic [IDX_W-1:0]  t_addr_h[64];
  logic [IDX_W-1:0]  r_addr_h[64];
  logic [IDX_W-1:0]  bb_h    [64];
  logic [2*N_PE-1:0] tsrc_h  [64];
  logic [2*N_PE-1:0] rsrc_h  [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then samples cycle n=1.. until done or the cycle budget runs out.
  task automatic run_job(input int tl, input int rl, input int hold_from, input int hold_len,
                         input int dup_at, input int bound);
    for (int i = 0; i < 64; i++) begin
      pv_h[i] = '0; t_rd_h[i] = 1'b0; r_rd_h[i] = 1'b0; busy_h[i] = 1'b0;
      t_addr_h[i] = '0; r_addr_h[i] = '0; bb_h[i] = '0; tsrc_h[i] = '0; rsrc_h[i] = '0;
    end
    done_cyc = -1; pv_bits = 0; t_rds = 0; r_rds = 0; hold_viol = 0;
    t_len = IDX_W'(tl); r_len = IDX_W'(rl);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= bound; n++) begin
      pv_h[n] = path_vld; t_rd_h[n] = t_rd; r_rd_h[n] = r_rd; busy_h[n] = busy;
      t_addr_h[n] = t_addr; r_addr_h[n] = r_addr; bb_h[n] = band_base;
      tsrc_h[n] = sa_tsrc; rsrc_h[n] = sa_rsrc;
      pv_bits += $countones(path_vld);
      t_rds += int'(t_rd);
      r_rds += int'(r_rd);
      if (hold && (t_rd || r_rd || sa_ena || (|path_vld))) hold_viol++;
      if (done) begin
        done_cyc = n;
        break;
      end
      start = (n == dup_at);
      if (start) begin t_len = 5'd3; r_len = 5'd2; end
      if (hold_len > 0 && n == hold_from - 1) hold = 1'b1;
      if (hold_len > 0 && n == hold_from + hold_len - 1) hold = 1'b0;
      tick();
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; hold = 1'b0; t_len = '0; r_len = '0;
`ifdef SYSTARR_SCHED_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_band_base", 32'(band_base), 32'd0);
    chk("rst_tsrc", 32'(sa_tsrc), 32'd0);
    chk("rst_path_vld", 32'(path_vld), 32'd0);
    nrst = 1'b1;
    tick();

    // Single band, duplicate start in LOAD must be ignored
    run_job(6, 4, 0, 0, 4, 40);
    chk("b1_done_cyc", 32'(done_cyc), 32'd18);
    chk("b1_t_addr_n1", 32'(t_addr_h[1]), 32'd0);
    chk("b1_t_addr_n6", 32'(t_addr_h[6]), 32'd5);
    chk("b1_t_rd_n6", 32'(t_rd_h[6]), 32'd1);
    chk("b1_t_rd_n7", 32'(t_rd_h[7]), 32'd0);
    chk("b1_tsrc_k1", 32'(tsrc_h[2]), 32'h556);
    chk("b1_tsrc_stream", 32'(tsrc_h[9]), 32'h000);
    chk("b1_r_addr_c0", 32'(r_addr_h[8]), 32'd0);
    chk("b1_r_addr_c3", 32'(r_addr_h[11]), 32'd3);
    chk("b1_r_rd_c4", 32'(r_rd_h[12]), 32'd0);
    chk("b1_rsrc_c1", 32'(rsrc_h[9]), 32'h955);
    chk("b1_rsrc_c6", 32'(rsrc_h[14]), 32'hD55);
    chk("b1_pv_c0", 32'(pv_h[8]), 32'h00);
    chk("b1_pv_c1", 32'(pv_h[9]), 32'b100000);
    chk("b1_pv_c4", 32'(pv_h[12]), 32'b111100);
    chk("b1_pv_c6", 32'(pv_h[14]), 32'b001111);
    chk("b1_pv_c9", 32'(pv_h[17]), 32'b000001);
    chk("b1_pv_bits", 32'(pv_bits), 32'd24);
    chk("b1_t_rds", 32'(t_rds), 32'd6);
    chk("b1_r_rds", 32'(r_rds), 32'd4);
    chk("b1_busy_n1", 32'(busy_h[1]), 32'd1);
    tick();
    chk("b1_busy_after", 32'(busy), 32'd0);
    chk("b1_done_after", 32'(done), 32'd0);

    // Two bands, partial second band
    run_job(8, 3, 0, 0, 0, 60);
    chk("b2_done_cyc", 32'(done_cyc), 32'd33);
    chk("b2_base_band1", 32'(bb_h[1]), 32'd0);
    chk("b2_base_band2", 32'(bb_h[17]), 32'd6);
    chk("b2_t_addr_n17", 32'(t_addr_h[17]), 32'd6);
    chk("b2_t_rd_n18", 32'(t_rd_h[18]), 32'd1);
    chk("b2_t_rd_n19", 32'(t_rd_h[19]), 32'd0);
    chk("b2_tsrc_real", 32'(tsrc_h[18]), 32'h556);
    chk("b2_tsrc_zero", 32'(tsrc_h[20]), 32'h557);
    chk("b2_pv_band2_c2", 32'(pv_h[26]), 32'b110000);
    chk("b2_pv_band2_c4", 32'(pv_h[28]), 32'b010000);
    chk("b2_pv_bits", 32'(pv_bits), 32'd24);
    chk("b2_t_rds", 32'(t_rds), 32'd8);
    chk("b2_r_rds", 32'(r_rds), 32'd6);
    tick();

    // Hold for 3 cycles at stream c=2
`ifdef SYSTARR_SCHED_STAT_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
`endif
    run_job(6, 4, 10, 3, 0, 40);
    chk("h_done_cyc", 32'(done_cyc), 32'd21);
    chk("h_violations", 32'(hold_viol), 32'd0);
    chk("h_pv_c1", 32'(pv_h[9]), 32'b100000);
    chk("h_pv_gap", 32'(pv_h[11]), 32'h00);
    chk("h_r_rd_gap", 32'(r_rd_h[10]), 32'd0);
    chk("h_pv_c2", 32'(pv_h[13]), 32'b110000);
    chk("h_r_rd_c2", 32'(r_rd_h[13]), 32'd1);
    chk("h_r_addr_c2", 32'(r_addr_h[13]), 32'd2);
    chk("h_pv_bits", 32'(pv_bits), 32'd24);
    chk("h_r_rds", 32'(r_rds), 32'd4);
    tick();
`ifdef SYSTARR_SCHED_STAT_EN
    chk("stat_cycles", 32'(stat_cycles), 32'd18);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_cleared", 32'(stat_cycles), 32'd0);
`endif

    // Zero-length job
    run_job(0, 5, 0, 0, 0, 5);
    chk("z_done_cyc", 32'(done_cyc), 32'd1);
    chk("z_busy", 32'(busy_h[1]), 32'd0);
    chk("z_t_rds", 32'(t_rds), 32'd0);
    chk("z_r_rds", 32'(r_rds), 32'd0);
    tick();

    // Reset during LOAD of band 2
    t_len = 5'd8; r_len = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    chk("r_base_before", 32'(band_base), 32'd6);
    nrst = 1'b0;
    #1;
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_band_base", 32'(band_base), 32'd0);
    chk("r_t_rd", 32'(t_rd), 32'd0);
    chk("r_t_addr", 32'(t_addr), 32'd0);
    chk("r_sa_ena", 32'(sa_ena), 32'd0);
    chk("r_tsrc", 32'(sa_tsrc), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      tick();
    end
    chk("r_no_done", 32'(done_seen), 32'd0);
    nrst = 1'b1;
    tick();
    run_job(6, 4, 0, 0, 0, 40);
    chk("r2_done_cyc", 32'(done_cyc), 32'd18);
    chk("r2_base", 32'(bb_h[1]), 32'd0);
    chk("r2_pv_bits", 32'(pv_bits), 32'd24);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
